// File: rtl/cache_miss_handler.sv
// Cache miss handler: writes back a dirty victim line beat by beat, then refills the
// missing line beat by beat through a single-outstanding-request driver interface.
module cache_miss_handler #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned LINE_BYTES     = 32
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     miss_addr,
    input  logic                          miss_dirty,
    input  logic [AXI_ADDR_WIDTH-1:0]     victim_addr,
    input  logic [LINE_BYTES*8-1:0]       victim_line,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic                          req_is_write,
    output logic [AXI_ADDR_WIDTH-1:0]     req_addr,
    output logic [7:0]                    req_len,
    output logic [2:0]                    req_size,
    output logic [AXI_DATA_WIDTH-1:0]     req_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   req_wstrb,
    input  logic                          rsp_valid,
    input  logic [AXI_DATA_WIDTH-1:0]     rsp_data,
    input  logic [1:0]                    rsp_resp,
    output logic                          fill_valid,
    output logic [AXI_ADDR_WIDTH-1:0]     fill_addr,
    output logic [LINE_BYTES*8-1:0]       fill_line,
    output logic                          fill_err
);

    localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned LINE_W     = LINE_BYTES * 8;
    localparam int unsigned LINE_BEATS = LINE_W / AXI_DATA_WIDTH;
    localparam int unsigned BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = ~AXI_ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_RSP,
        RF_REQ,
        RF_RSP,
        FILL
    } state_t;

    state_t                      state_q, state_n;
    logic [BEAT_W-1:0]           beat_q, beat_n;
    logic                        err_q, err_n;
    logic [AXI_ADDR_WIDTH-1:0]   miss_base_q, miss_base_n;
    logic [AXI_ADDR_WIDTH-1:0]   victim_base_q, victim_base_n;
    logic [LINE_W-1:0]           victim_line_q, victim_line_n;
    logic [LINE_W-1:0]           line_q, line_n;

    logic                        req_valid_q, req_valid_n;
    logic                        req_is_write_q, req_is_write_n;
    logic [AXI_ADDR_WIDTH-1:0]   req_addr_q, req_addr_n;
    logic [AXI_DATA_WIDTH-1:0]   req_wdata_q, req_wdata_n;
    logic [BEAT_BYTES-1:0]       req_wstrb_q, req_wstrb_n;
    logic                        fill_valid_q, fill_valid_n;
    logic                        fill_err_q, fill_err_n;

    // Byte address of beat b within the line starting at base
    function automatic logic [AXI_ADDR_WIDTH-1:0] beat_addr(
        input logic [AXI_ADDR_WIDTH-1:0] base,
        input logic [BEAT_W-1:0]         b
    );
        return base + AXI_ADDR_WIDTH'(b) * AXI_ADDR_WIDTH'(BEAT_BYTES);
    endfunction

    function automatic logic [AXI_DATA_WIDTH-1:0] beat_of(
        input logic [LINE_W-1:0] line,
        input logic [BEAT_W-1:0] b
    );
        logic [AXI_DATA_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < int'(LINE_BEATS); k++) begin
            if (b == BEAT_W'(k)) r = line[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        end
        return r;
    endfunction

    // Next-state and datapath; request/fill outputs are computed from the next state so
    // they come straight out of flops and stay stable while the driver stalls.
    always_comb begin
        state_n        = state_q;
        beat_n         = beat_q;
        err_n          = err_q;
        miss_base_n    = miss_base_q;
        victim_base_n  = victim_base_q;
        victim_line_n  = victim_line_q;
        line_n         = line_q;
        req_valid_n    = 1'b0;
        req_is_write_n = req_is_write_q;
        req_addr_n     = req_addr_q;
        req_wdata_n    = req_wdata_q;
        req_wstrb_n    = req_wstrb_q;
        fill_valid_n   = 1'b0;
        fill_err_n     = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    miss_base_n   = miss_addr & LINE_MASK;
                    victim_base_n = victim_addr & LINE_MASK;
                    victim_line_n = victim_line;
                    beat_n        = '0;
                    err_n         = 1'b0;
                    state_n       = miss_dirty ? WB_REQ : RF_REQ;
                end
            end
            WB_REQ: begin
                if (req_ready) state_n = WB_RSP;
            end
            WB_RSP: begin
                if (rsp_valid) begin
                    err_n = err_q | (rsp_resp != 2'b00);
                    if (beat_q == LAST_BEAT) begin
                        beat_n  = '0;
                        state_n = RF_REQ;
                    end else begin
                        beat_n  = beat_q + BEAT_W'(1);
                        state_n = WB_REQ;
                    end
                end
            end
            RF_REQ: begin
                if (req_ready) state_n = RF_RSP;
            end
            RF_RSP: begin
                if (rsp_valid) begin
                    for (int k = 0; k < int'(LINE_BEATS); k++) begin
                        if (beat_q == BEAT_W'(k)) line_n[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = rsp_data;
                    end
                    err_n = err_q | (rsp_resp != 2'b00);
                    if (beat_q == LAST_BEAT) begin
                        state_n = FILL;
                    end else begin
                        beat_n  = beat_q + BEAT_W'(1);
                        state_n = RF_REQ;
                    end
                end
            end
            FILL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            WB_REQ: begin
                req_valid_n    = 1'b1;
                req_is_write_n = 1'b1;
                req_addr_n     = beat_addr(victim_base_n, beat_n);
                req_wdata_n    = beat_of(victim_line_n, beat_n);
                req_wstrb_n    = '1;
            end
            RF_REQ: begin
                req_valid_n    = 1'b1;
                req_is_write_n = 1'b0;
                req_addr_n     = beat_addr(miss_base_n, beat_n);
                req_wstrb_n    = '0;
            end
            FILL: begin
                fill_valid_n = 1'b1;
                fill_err_n   = err_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            err_q          <= 1'b0;
            miss_base_q    <= '0;
            victim_base_q  <= '0;
            victim_line_q  <= '0;
            line_q         <= '0;
            req_valid_q    <= 1'b0;
            req_is_write_q <= 1'b0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_wstrb_q    <= '0;
            fill_valid_q   <= 1'b0;
            fill_err_q     <= 1'b0;
        end else begin
            state_q        <= state_n;
            beat_q         <= beat_n;
            err_q          <= err_n;
            miss_base_q    <= miss_base_n;
            victim_base_q  <= victim_base_n;
            victim_line_q  <= victim_line_n;
            line_q         <= line_n;
            req_valid_q    <= req_valid_n;
            req_is_write_q <= req_is_write_n;
            req_addr_q     <= req_addr_n;
            req_wdata_q    <= req_wdata_n;
            req_wstrb_q    <= req_wstrb_n;
            fill_valid_q   <= fill_valid_n;
            fill_err_q     <= fill_err_n;
        end
    end

    assign miss_ready   = (state_q == IDLE);
    assign req_valid    = req_valid_q;
    assign req_is_write = req_is_write_q;
    assign req_addr     = req_addr_q;
    assign req_len      = 8'd0;
    assign req_size     = 3'($clog2(BEAT_BYTES));
    assign req_wdata    = req_wdata_q;
    assign req_wstrb    = req_wstrb_q;
    assign fill_valid   = fill_valid_q;
    assign fill_addr    = miss_base_q;
    assign fill_line    = line_q;
    assign fill_err     = fill_err_q;

endmodule
